// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 write engine: FSM state encoding, the
// command codes that need the long execution wait, and the predicate that
// recognises them.
package hd44780_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StEHigh,
    StHold,
    StExec
  } state_e;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  // Clear (0x01) and return-home (0x02/0x03, bit 0 is don't-care) are the only
  // instructions whose execution time is ~1.64 ms instead of ~40 us.
  function automatic logic is_long_cmd(input logic dc, input logic [7:0] data);
    return !dc && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered level and full flag.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset (flushes contents)
//   push, wdata  - write request and data; ignored while full
//   pop, rdata   - read request; rdata shows the head combinationally
//   full, empty  - status derived from the registered level
//   level        - number of entries held
// Push and pop in the same cycle both take effect.
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned FIFO_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_BITS:0]    level
);

  localparam int unsigned Depth = 2 ** FIFO_BITS;
  localparam logic [FIFO_BITS:0] DepthLvl = (FIFO_BITS + 1)'(Depth);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [FIFO_BITS-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_BITS:0]    level_q, level_d;
  logic                  full_q;
  logic                  do_push, do_pop;

  assign do_push = push && !full_q;
  assign do_pop  = pop && (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + 1'b1;
    end else if (do_pop && !do_push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == DepthLvl);
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/hd44780_writer.sv
// HD44780 write engine. Bytes pushed by the CPU are queued, then each is put
// on the LCD bus, strobed with E after a setup time, held, and followed by the
// instruction's execution wait before the next byte is started.
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   wr_valid, wr_dc, wr_data   - push request, RS value (0 cmd / 1 data), byte
//   wr_ready                   - FIFO not full
//   fifo_level                 - entries queued
//   busy                       - FIFO non-empty or engine active
//   hd_dc, hd_e, hd_data       - registered LCD RS, E and DB7..0
module hd44780_writer
  import hd44780_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES     = 2,
  parameter int unsigned E_HIGH_CYCLES    = 13,
  parameter int unsigned HOLD_CYCLES      = 1,
  parameter int unsigned EXEC_CYCLES      = 1080,
  parameter int unsigned LONG_EXEC_CYCLES = 44280,
  parameter int unsigned COUNTER_WIDTH    = 16,
  parameter int unsigned FIFO_BITS        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_valid,
  input  logic                 wr_dc,
  input  logic [7:0]           wr_data,
  output logic                 wr_ready,
  output logic [FIFO_BITS:0]   fifo_level,
  output logic                 busy,
  output logic                 hd_dc,
  output logic                 hd_e,
  output logic [7:0]           hd_data
);

  localparam longint unsigned CntMax = (64'd1 << COUNTER_WIDTH) - 64'd1;

  // Every phase lasts at least one cycle and its length must fit the counter.
  if (COUNTER_WIDTH < 1 || COUNTER_WIDTH > 32 || FIFO_BITS < 1 ||
      SETUP_CYCLES < 1 || E_HIGH_CYCLES < 1 || HOLD_CYCLES < 1 ||
      EXEC_CYCLES < 1 || LONG_EXEC_CYCLES < 1 ||
      longint'(SETUP_CYCLES) > CntMax || longint'(E_HIGH_CYCLES) > CntMax ||
      longint'(HOLD_CYCLES) > CntMax || longint'(EXEC_CYCLES) > CntMax ||
      longint'(LONG_EXEC_CYCLES) > CntMax) begin : g_bad_params
    $error("hd44780_writer: timing parameter out of range");
  end

  localparam logic [COUNTER_WIDTH-1:0] SetupLoad = COUNTER_WIDTH'(SETUP_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] EHighLoad = COUNTER_WIDTH'(E_HIGH_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] HoldLoad  = COUNTER_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] ExecLoad  = COUNTER_WIDTH'(EXEC_CYCLES - 1);
  localparam logic [COUNTER_WIDTH-1:0] LongLoad  = COUNTER_WIDTH'(LONG_EXEC_CYCLES - 1);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic                     dc_q, dc_d;
  logic [7:0]               data_q, data_d;
  logic                     e_q, e_d;
  logic                     long_q, long_d;
  logic                     pop, start, cnt_zero;
  logic                     fifo_full, fifo_empty;
  logic [8:0]               head;

  sync_fifo #(
    .DATA_WIDTH (9),
    .FIFO_BITS  (FIFO_BITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .wdata ({wr_dc, wr_data}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dc_d    = dc_q;
    data_d  = data_q;
    e_d     = e_q;
    long_d  = long_q;
    start   = 1'b0;

    unique case (state_q)
      StIdle: begin
        start = !fifo_empty;
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StEHigh;
          e_d     = 1'b1;
          cnt_d   = EHighLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StEHigh: begin
        if (cnt_zero) begin
          state_d = StHold;
          e_d     = 1'b0;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          state_d = StExec;
          cnt_d   = long_q ? LongLoad : ExecLoad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StExec: begin
        if (cnt_zero) begin
          // Chain straight into the next byte when one is waiting.
          start   = !fifo_empty;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        e_d     = 1'b0;
      end
    endcase

    if (start) begin
      state_d = StSetup;
      dc_d    = head[8];
      data_d  = head[7:0];
      long_d  = is_long_cmd(head[8], head[7:0]);
      cnt_d   = SetupLoad;
    end
  end

  assign pop = start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dc_q    <= 1'b0;
      data_q  <= 8'h00;
      e_q     <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dc_q    <= dc_d;
      data_q  <= data_d;
      e_q     <= e_d;
      long_q  <= long_d;
    end
  end

  assign wr_ready = !fifo_full;
  assign busy     = !fifo_empty || (state_q != StIdle);
  assign hd_dc    = dc_q;
  assign hd_e     = e_q;
  assign hd_data  = data_q;

endmodule

// File: tb/tb_hd44780_writer.sv
// Self-checking bench for hd44780_writer. The reference model records, for
// every accepted byte, the edge it was accepted on and the edge its bus cycle
// starts; FIFO level, busy and pulse timing are all derived from that list.
module tb_hd44780_writer;

  localparam int SetupC = 2;
  localparam int EHighC = 13;
  localparam int HoldC  = 1;
  localparam int ExecC  = 1080;
  localparam int LongC  = 44280;
  localparam int Depth  = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_dc = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, busy, hd_dc, hd_e;
  logic [2:0] fifo_level;
  logic [7:0] hd_data;

  hd44780_writer dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_dc      (wr_dc),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .fifo_level (fifo_level),
    .busy       (busy),
    .hd_dc      (hd_dc),
    .hd_e       (hd_e),
    .hd_data    (hd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;  // index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         acc;
    int         start;
    int         per;
    logic       dc;
    logic [7:0] data;
  } entry_t;

  entry_t model_q[$];
  entry_t exp_q[$];
  bit     chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int period_of(input logic dc, input logic [7:0] d);
    bit long_cmd;
    long_cmd = (dc == 1'b0) && (d >= 8'd1) && (d <= 8'd3);
    return SetupC + EHighC + HoldC + (long_cmd ? LongC : ExecC);
  endfunction

  function automatic int level_after(input int c);
    int n = 0;
    foreach (model_q[i]) if (model_q[i].acc <= c && model_q[i].start > c) n++;
    return n;
  endfunction

  function automatic bit active_after(input int c);
    foreach (model_q[i])
      if (model_q[i].start <= c && c < model_q[i].start + model_q[i].per) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_end();
    int m = 0;
    foreach (model_q[i]) if (model_q[i].start + model_q[i].per > m)
      m = model_q[i].start + model_q[i].per;
    return m;
  endfunction

  // Called just after a falling edge; drives one push for the next rising edge.
  task automatic push(input logic dc, input logic [7:0] d);
    int     t;
    entry_t e;
    t = cyc + 1;
    wr_valid = 1'b1;
    wr_dc    = dc;
    wr_data  = d;
    if (level_after(t - 1) < Depth) begin
      e.acc   = t;
      e.start = (model_end() > t + 1) ? model_end() : t + 1;
      e.per   = period_of(dc, d);
      e.dc    = dc;
      e.data  = d;
      model_q.push_back(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic drain();
    while (cyc < model_end() + 2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    model_q.delete();
  endtask

  // Monitor: compares the DUT against the model on every falling edge.
  bit     prev_e = 1'b0;
  int     hi_cnt = 0;
  entry_t mon_e;
  always @(negedge clk) begin
    if (!chk_en) begin
      prev_e = hd_e;
      hi_cnt = 0;
    end else begin
      check("fifo_level", fifo_level, level_after(cyc));
      check("wr_ready", wr_ready, level_after(cyc) < Depth);
      check("busy", busy, (level_after(cyc) > 0) || active_after(cyc));
      foreach (model_q[i]) if (model_q[i].start == cyc) begin
        check("bus_data", hd_data, model_q[i].data);
        check("bus_dc", hd_dc, model_q[i].dc);
      end
      if (hd_e && !prev_e) begin
        check("pulse_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("pulse_data", hd_data, mon_e.data);
          check("pulse_dc", hd_dc, mon_e.dc);
          check("e_rise_cycle", cyc, mon_e.start + SetupC);
        end
        hi_cnt = 1;
      end else if (hd_e) begin
        hi_cnt++;
      end
      if (!hd_e && prev_e) check("e_high_width", hi_cnt, EHighC);
      prev_e = hd_e;
    end
  end

  initial begin
    int         target;
    int         gap;
    logic       rdc;
    logic [7:0] rdata;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_hd_e", hd_e, 1'b0);
    check("rst_hd_dc", hd_dc, 1'b0);
    check("rst_hd_data", hd_data, 8'h00);
    check("rst_wr_ready", wr_ready, 1'b1);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // Single data byte.
    push(1'b1, 8'h41);
    drain();

    // Long command followed by data, then a normal command for contrast.
    push(1'b0, 8'h01);
    push(1'b1, 8'h42);
    drain();
    push(1'b0, 8'h04);
    push(1'b1, 8'h42);
    drain();

    // Overflow: six pushes while the engine is busy.
    push(1'b1, 8'h50);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 6; i++) push(1'b1, 8'h60 + 8'(i));
    drain();

    // Reset in the middle of the E pulse with bytes queued.
    push(1'b0, 8'h30);
    push(1'b1, 8'h33);
    push(1'b1, 8'h34);
    target = model_q[0].start + 8;
    while (cyc < target) @(negedge clk);
    check("pre_reset_hd_e", hd_e, 1'b1);
    #2;
    chk_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("async_rst_hd_e", hd_e, 1'b0);
    check("async_rst_level", fifo_level, 0);
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_ready", wr_ready, 1'b1);
    model_q.delete();
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    push(1'b1, 8'h31);
    drain();

    // Push coinciding with the EXEC->SETUP pop at level 1.
    push(1'b1, 8'h70);
    push(1'b1, 8'h71);
    target = model_q[1].start;
    while (cyc < target - 1) @(negedge clk);
    push(1'b1, 8'h72);
    check("coincident_level", fifo_level, 1);
    drain();

    // Random bursts of short commands and data.
    for (int i = 0; i < 8; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk);
      rdata = 8'($urandom);
      rdc   = 1'($urandom);
      if (!rdc && rdata >= 8'd1 && rdata <= 8'd3) rdc = 1'b1;
      push(rdc, rdata);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
